serial_adder_ctrl: RTL
======================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial adder: accepts two WIDTH-bit operands on a start strobe and adds them LSB-first,
//  one bit per clock, through a half-adder pair plus a carry flip-flop.
//  Sits upstream of the combinational half-adder cells and sequences their operands.
//  Trades WIDTH cycles of latency for a single-bit datapath.
//  Result and carry-out are presented in registers with a one-cycle done pulse.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits; legal range 2..32
// PORTS
//  clk    in   1      single clock, rising edge
//  rst    in   1      asynchronous reset, active-high
//  start  in   1      request; sampled only while not busy
//  a      in   WIDTH  operand A; captured on the accepted start edge
//  b      in   WIDTH  operand B; captured on the accepted start edge
//  sum    out  WIDTH  registered result; holds until next completion
//  cout   out  1      registered carry-out (or borrow-not when SERIAL_SUB_EN and sub=1)
//  busy   out  1      high while bits are being processed
//  done   out  1      one-cycle pulse when sum/cout update
//  sub    in   1      only present with SERIAL_SUB_EN; captured with a/b
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE; sum=0, cout=0, busy=0, done=0; internal a/b shift regs, bit count and carry FF = 0.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE: start=1 at an edge -> latch a,b; carry=0; cnt=0; go RUN; busy=1 from that edge.
//  - IDLE: start=0 -> stay IDLE.
//  - RUN, each edge, per bit:
//    - s_bit = a[0]^b[0]^carry; carry <= (a[0]&b[0]) | (carry&(a[0]^b[0])), i.e. two half adders plus OR.
//    - Shift a,b right; shift s_bit into MSB of internal sum shift reg; cnt <= cnt+1.
//  - RUN, edge processing bit WIDTH-1:
//    - Load sum output from the completed shift reg; cout <= final carry.
//    - done <= 1; busy <= 0; go DONE.
//  - Latency: done is high exactly WIDTH edges after the accepted start edge; throughput 1 op per WIDTH+1 cycles.
//  - DONE: done=1 for this one cycle only.
//    - Next edge with start=1 -> accept new op as in IDLE; done falls; go RUN.
//    - Otherwise go IDLE.
//  - start while busy=1: ignored, not queued; a/b changes during RUN have no effect.
//  - sum/cout change only on a completion edge or reset; never mid-operation.
//  - Arithmetic is modulo 2^WIDTH; carry out of MSB goes to cout only. cnt wraps never (terminal at WIDTH-1).
//  - rst asserted mid-RUN: operation aborted, all outputs to reset values immediately; no done pulse.
//  - Illegal/unused state encodings recover to IDLE.
// CONFIGURATION
//  SERIAL_SUB_EN defined:
//    - adds input port sub; when sub=1 at accept, the B operand is bit-inverted as it is shifted and the initial carry=1 (A-B, two's complement).
//    - cout=1 means no borrow.
//    - sub=0 behaves exactly as plain add.
//  SERIAL_SUB_EN undefined: no sub port; add only; initial carry always 0.
// TESTING (WIDTH=8)
//  1. Reset, then a=0x0F b=0x01 start 1 cycle -> busy high 8 cycles, done pulse on 8th edge, sum=0x10 cout=0.
//  2. a=0xFF b=0x01 -> sum=0x00 cout=1; a=0xFF b=0xFF -> sum=0xFE cout=1.
//  3. start held high continuously, operands changed during RUN -> ops back-to-back every 9 cycles.
//     - Each result uses only the operands present at its accept edge; extra starts ignored.
//  4. rst pulsed 4 cycles into a run (a=0x55 b=0xAA) -> sum=0, cout=0, busy=0, no done.
//     - Next op a=0x55 b=0xAA -> sum=0xFF cout=0.
//  5. Idle with start=0 for 20 cycles after a result -> sum/cout hold, done stays 0.
//  6. SERIAL_SUB_EN: sub=1 a=0x10 b=0x01 -> sum=0x0F cout=1; sub=1 a=0x01 b=0x02 -> sum=0xFF cout=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial LSB-first adder with registered sum/cout and a one-cycle done pulse.
// Optional subtract mode (A-B) when SERIAL_SUB_EN is defined.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             w_accept, w_last, w_s, w_c, w_sub;

`ifdef SERIAL_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    // Two half adders plus OR: sum bit and carry for the current LSB.
    assign w_s  = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c  = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    assign busy = r_state == RUN;
    assign done = r_state == DONE;

    always_comb begin
        w_next   = IDLE;
        w_accept = 1'b0;
        w_last   = r_cnt == LAST;
        case (r_state)
            IDLE, DONE: begin
                w_accept = start;
                w_next   = start ? RUN : IDLE;
            end
            RUN:     w_next = w_last ? DONE : RUN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else if (w_accept) begin
            // Subtract is A + ~B + 1: invert B once at capture, seed carry with 1.
            r_a     <= a;
            r_b     <= b ^ {WIDTH{w_sub}};
            r_carry <= w_sub;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_c;
            r_acc   <= {w_s, r_acc[WIDTH-1:1]};
            r_cnt   <= w_last ? r_cnt : r_cnt + CW'(1);
            if (w_last) begin
                sum  <= {w_s, r_acc[WIDTH-1:1]};
                cout <= w_c;
            end
        end
    end
endmodule
